mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle MIPS control unit; successor to the single-cycle decoder. Decodes Op/Funct from the
//  datapath IR and sequences BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT, driving per-state strobes and a
//  shared mem_req/mem_ready handshake. Adds a memory timeout and optional sub-word access support.
// PARAMETERS
//  TIMEOUT      16  cycles without mem_ready before bus error; 0 = wait forever
//  SUPPORT_SUB  1   1: lbu/lhu/sb/sh legal; 0: they decode as illegal
//  CNT_W        8   width of wait counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  op         in   6  IR[31:26]; datapath holds it stable from DECODE until the next FETCH
//  funct      in   6  IR[5:0]
//  alu_zero   in   1  ALU zero flag, valid in EXEC
//  mem_ready  in   1  memory completes current request this cycle
//  mem_req    out  1  memory request, held until mem_ready
//  mem_we     out  1  write qualifier for mem_req
//  mem_size   out  2  0 word, 1 byte, 2 half
//  ir_we      out  1  latch fetched word into IR
//  pc_we      out  1  update PC
//  pc_src     out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs
//  reg_write  out  1  register-file write strobe
//  reg_dst    out  2  0 rt, 1 rd, 2 $31
//  wb_sel     out  2  0 ALU, 1 mem data, 2 PC (already +4)
//  alu_src    out  1  0 rt, 1 extended imm
//  ext_op     out  2  0 zero, 1 lui (imm<<16), 2 sign
//  alu_op     out  4  0 add, 1 sub, 2 or; others reserved
//  instr_done out  1  1-cycle pulse in the completing state of each instruction
//  illegal    out  1  1-cycle pulse in DECODE on unsupported encoding
//  bus_err    out  1  sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset (async, low): state=BOOT, wait counter=0, bus_err=0; all strobes 0 while low and in BOOT.
//  BOOT -> FETCH after 1 cycle. Strobes are decoded from state + op/funct; none is gated by bus_err.
//  FETCH: mem_req=1, mem_we=0, mem_size=0; on mem_ready: ir_we=1, pc_we=1, pc_src=0 -> DECODE.
//  DECODE: j: pc_we, pc_src=2. jal: pc_we, pc_src=2, reg_write, reg_dst=2, wb_sel=2.
//   jr: pc_we, pc_src=3. jalr: pc_we, pc_src=3, reg_write, reg_dst=1, wb_sel=2.
//   Jump instructions pulse instr_done and go to FETCH. Illegal: pulse illegal, no writes -> FETCH.
//   All others -> EXEC.
//  EXEC: addu/subu alu_src=0, alu_op 0/1; ori ext=0, op 2; lui ext=1, op 2 (rs=$0 datapath
//   convention); loads/stores ext=2, op 0, alu_src=1.
//   beq/bne: alu_op=1; pc_we=1, pc_src=1 iff alu_zero==beq; instr_done -> FETCH.
//   ALU types -> WB; loads/stores -> MEM.
//  MEM: mem_req=1, mem_we=store, mem_size by opcode (lw/sw 0, lbu/sb 1, lhu/sh 2); wait for mem_ready.
//   Store -> FETCH with instr_done. Load -> WB.
//  WB: reg_write=1; ALU: reg_dst=1 (R-type) or 0 (ori/lui), wb_sel=0. Load: reg_dst=0, wb_sel=1.
//   WB pulses instr_done -> FETCH.
//  Latency with zero wait: j/jal/jr/jalr 2, beq/bne 3, ALU 4, store 4, load 5 cycles.
//   Each FETCH/MEM wait cycle adds 1.
//  Wait counter: cleared on entering FETCH/MEM and on mem_ready; increments each cycle mem_req=1
//   and mem_ready=0. If TIMEOUT!=0 and counter==TIMEOUT-1 with no mem_ready: bus_err<=1 -> HALT.
//   mem_ready in that same cycle wins (normal completion, no error).
//  HALT: all strobes 0, remains until reset. Reset asserted mid-instruction aborts it
//   immediately (no pc_we/reg_write issued).
//  funct decoded only when op==0; unknown funct -> illegal.
//  op==0, funct==0 (sll nop) -> illegal. Sub-word ops illegal when SUPPORT_SUB=0.
// TESTING
//  1 addu (op 0, funct 0x21), mem_ready=1 always -> 4 cycles; WB: reg_write, reg_dst=1; instr_done once.
//  2 lw (0x23), mem_ready in MEM delayed 3 cycles -> 8 cycles; WB wb_sel=1; mem_we=0 throughout.
//  3 beq with alu_zero=1 -> EXEC pc_we=1, pc_src=1; bne with alu_zero=1 -> pc_we=0.
//  4 jal (0x03) -> DECODE: pc_we, pc_src=2, reg_write, reg_dst=2, wb_sel=2; next cycle FETCH.
//  5 TIMEOUT=16, mem_ready held 0 in FETCH -> bus_err rises after 16 req cycles, HALT;
//    reset low -> BOOT, bus_err=0.
//  6 SUPPORT_SUB=0, sb (0x28) -> illegal pulse in DECODE, no mem_req; reset low in MEM -> strobes 0 at once.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit.
// Sequences BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT and decodes the per-state
// strobes from the current state plus the op/funct fields held in the IR.
// One mem_req/mem_ready handshake serves both instruction fetch and data
// access. A wait counter turns an unanswered request into a sticky bus error.

module mc_controller #(
    parameter int unsigned TIMEOUT     = 16,  // cycles without mem_ready before bus error; 0 = never
    parameter int unsigned SUPPORT_SUB = 1,   // 0 makes lbu/lhu/sb/sh decode as illegal
    parameter int unsigned CNT_W       = 8    // 2**CNT_W must exceed TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active low
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_size,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
);

    // ------------------------------------------------------------------
    // Instruction encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ------------------------------------------------------------------
    // Control field encodings seen by the datapath
    // ------------------------------------------------------------------
    localparam logic [1:0] SIZE_WORD  = 2'd0;
    localparam logic [1:0] SIZE_BYTE  = 2'd1;
    localparam logic [1:0] SIZE_HALF  = 2'd2;

    localparam logic [1:0] PC_SEQ     = 2'd0;
    localparam logic [1:0] PC_BRANCH  = 2'd1;
    localparam logic [1:0] PC_JUMP    = 2'd2;
    localparam logic [1:0] PC_RS      = 2'd3;

    localparam logic [1:0] DST_RT     = 2'd0;
    localparam logic [1:0] DST_RD     = 2'd1;
    localparam logic [1:0] DST_RA     = 2'd2;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC      = 2'd2;

    localparam logic [1:0] EXT_ZERO   = 2'd0;
    localparam logic [1:0] EXT_LUI    = 2'd1;
    localparam logic [1:0] EXT_SIGN   = 2'd2;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_OR     = 4'd2;

    localparam bit SUB_EN = (SUPPORT_SUB != 0);

    // Counter value seen in the last request cycle allowed to go unanswered.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    // Instruction classes: everything the sequencer and strobes depend on.
    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_ADDU,
        CL_SUBU,
        CL_ORI,
        CL_LUI,
        CL_LOAD,
        CL_STORE,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_JAL,
        CL_JR,
        CL_JALR
    } iclass_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    iclass_e          w_class;
    logic [1:0]       w_size;
    logic             w_ends_in_decode;
    logic             w_timeout;

    // Classify the IR fields; funct only matters for op==0, sub-word ops honour SUB_EN.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        w_class = CL_ILLEGAL;
        w_size  = SIZE_WORD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: w_class = CL_ADDU;
                    FN_SUBU: w_class = CL_SUBU;
                    FN_JR:   w_class = CL_JR;
                    FN_JALR: w_class = CL_JALR;
                    default: w_class = CL_ILLEGAL;  // includes funct 0 (sll nop)
                endcase
            end
            OP_J:   w_class = CL_J;
            OP_JAL: w_class = CL_JAL;
            OP_BEQ: w_class = CL_BEQ;
            OP_BNE: w_class = CL_BNE;
            OP_ORI: w_class = CL_ORI;
            OP_LUI: w_class = CL_LUI;
            OP_LW:  w_class = CL_LOAD;
            OP_SW:  w_class = CL_STORE;
            OP_LBU: begin
                if (SUB_EN) begin
                    w_class = CL_LOAD;
                    w_size  = SIZE_BYTE;
                end
            end
            OP_LHU: begin
                if (SUB_EN) begin
                    w_class = CL_LOAD;
                    w_size  = SIZE_HALF;
                end
            end
            OP_SB: begin
                if (SUB_EN) begin
                    w_class = CL_STORE;
                    w_size  = SIZE_BYTE;
                end
            end
            OP_SH: begin
                if (SUB_EN) begin
                    w_class = CL_STORE;
                    w_size  = SIZE_HALF;
                end
            end
            default: w_class = CL_ILLEGAL;
        endcase
    end

    assign w_ends_in_decode = (w_class inside {CL_J, CL_JAL, CL_JR, CL_JALR, CL_ILLEGAL});

    // mem_ready in the last allowed cycle takes priority, so the timeout is only
    // consulted on the no-ready path of the sequencer.
    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == TO_LAST);

    // Sequencer: state, request wait counter and sticky bus error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            // Default clear: covers entering FETCH/MEM and completion on mem_ready.
            r_wait_cnt <= '0;
            case (r_state)
                S_BOOT: r_state <= S_FETCH;

                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        if (r_state == S_FETCH) begin
                            r_state <= S_DECODE;
                        end else if (w_class == CL_STORE) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (w_timeout) begin
                            r_bus_err <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    end
                end

                S_DECODE: r_state <= w_ends_in_decode ? S_FETCH : S_EXEC;

                S_EXEC: begin
                    if (w_class inside {CL_BEQ, CL_BNE}) begin
                        r_state <= S_FETCH;
                    end else if (w_class inside {CL_LOAD, CL_STORE}) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end

                S_WB: r_state <= S_FETCH;

                S_HALT: r_state <= S_HALT;

                default: r_state <= S_HALT;
            endcase
        end
    end

    // Per-state strobes decoded from state and instruction class; BOOT and HALT drive nothing.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_size   = SIZE_WORD;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SEQ;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        wb_sel     = WB_ALU;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SEQ;
                end
            end

            S_DECODE: begin
                case (w_class)
                    CL_J: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_JUMP;
                        instr_done = 1'b1;
                    end
                    CL_JAL: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = DST_RA;
                        wb_sel     = WB_PC;
                        instr_done = 1'b1;
                    end
                    CL_JR: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_RS;
                        instr_done = 1'b1;
                    end
                    CL_JALR: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_RS;
                        reg_write  = 1'b1;
                        reg_dst    = DST_RD;
                        wb_sel     = WB_PC;
                        instr_done = 1'b1;
                    end
                    CL_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end

            S_EXEC: begin
                case (w_class)
                    CL_ADDU: alu_op = ALU_ADD;
                    CL_SUBU: alu_op = ALU_SUB;
                    CL_ORI: begin
                        alu_src = 1'b1;
                        ext_op  = EXT_ZERO;
                        alu_op  = ALU_OR;
                    end
                    CL_LUI: begin
                        // rs is $0 by datapath convention, so OR yields imm<<16.
                        alu_src = 1'b1;
                        ext_op  = EXT_LUI;
                        alu_op  = ALU_OR;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src = 1'b1;
                        ext_op  = EXT_SIGN;
                        alu_op  = ALU_ADD;
                    end
                    CL_BEQ, CL_BNE: begin
                        alu_op     = ALU_SUB;
                        instr_done = 1'b1;
                        // Taken when equality matches the branch sense.
                        if (alu_zero == (w_class == CL_BEQ)) begin
                            pc_we  = 1'b1;
                            pc_src = PC_BRANCH;
                        end
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = (w_class == CL_STORE);
                mem_size   = w_size;
                instr_done = mem_ready && (w_class == CL_STORE);
            end

            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                if (w_class == CL_LOAD) begin
                    reg_dst = DST_RT;
                    wb_sel  = WB_MEM;
                end else if (w_class inside {CL_ADDU, CL_SUBU}) begin
                    reg_dst = DST_RD;
                    wb_sel  = WB_ALU;
                end else begin
                    reg_dst = DST_RT;
                    wb_sel  = WB_ALU;
                end
            end

            default: ;
        endcase
    end

    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller.
// Two instances share op/funct/alu_zero/mem_ready: dut_a (sub-word ops legal)
// and dut_b (sub-word ops illegal), each with its own reset; only the one
// selected by 'cur' is out of reset and observed. Expected strobes come from
// a per-instruction phase walk (FETCH [waits], DECODE, EXEC, MEM [waits], WB)
// built from the instruction's kind and the handshake timing the bench picks.

module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] mem_size;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    typedef enum int {PH_NONE, PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB} phase_t;

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_LBU, K_LHU, K_SW, K_SB, K_SH,
        K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR, K_ILL
    } kind_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        kind_t      k;
    } instr_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [5:0] op, funct;
    logic       alu_zero, mem_ready;
    ctl_t       a_ctl, b_ctl;
    logic       a_bus_err, b_bus_err;

    int         n_vec = 0;
    int         n_err = 0;
    bit         cur = 1'b0;          // 0 observes dut_a, 1 observes dut_b
    phase_t     abort_at = PH_NONE;  // phase in which reset is pulled mid-instruction
    bit         aborted = 1'b0;
    instr_t     tbl[$];

    mc_controller #(.TIMEOUT(16), .SUPPORT_SUB(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .op(op), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(a_ctl.mem_req), .mem_we(a_ctl.mem_we),
        .mem_size(a_ctl.mem_size), .ir_we(a_ctl.ir_we), .pc_we(a_ctl.pc_we),
        .pc_src(a_ctl.pc_src), .reg_write(a_ctl.reg_write), .reg_dst(a_ctl.reg_dst),
        .wb_sel(a_ctl.wb_sel), .alu_src(a_ctl.alu_src), .ext_op(a_ctl.ext_op),
        .alu_op(a_ctl.alu_op), .instr_done(a_ctl.instr_done), .illegal(a_ctl.illegal),
        .bus_err(a_bus_err)
    );

    mc_controller #(.TIMEOUT(16), .SUPPORT_SUB(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(rst_b), .op(op), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(b_ctl.mem_req), .mem_we(b_ctl.mem_we),
        .mem_size(b_ctl.mem_size), .ir_we(b_ctl.ir_we), .pc_we(b_ctl.pc_we),
        .pc_src(b_ctl.pc_src), .reg_write(b_ctl.reg_write), .reg_dst(b_ctl.reg_dst),
        .wb_sel(b_ctl.wb_sel), .alu_src(b_ctl.alu_src), .ext_op(b_ctl.ext_op),
        .alu_op(b_ctl.alu_op), .instr_done(b_ctl.instr_done), .illegal(b_ctl.illegal),
        .bus_err(b_bus_err)
    );

    function automatic instr_t mk(logic [5:0] o, logic [5:0] f, kind_t k);
        instr_t r;
        r.op = o;
        r.funct = f;
        r.k = k;
        return r;
    endfunction

    function automatic bit is_load(kind_t k);
        return k inside {K_LW, K_LBU, K_LHU};
    endfunction

    function automatic bit is_store(kind_t k);
        return k inside {K_SW, K_SB, K_SH};
    endfunction

    function automatic logic [1:0] size_of(kind_t k);
        if (k inside {K_LBU, K_SB}) return 2'd1;
        if (k inside {K_LHU, K_SH}) return 2'd2;
        return 2'd0;
    endfunction

    // dut_b treats every sub-word access as an illegal encoding.
    function automatic kind_t eff_kind(kind_t k);
        if (cur && (k inside {K_LBU, K_LHU, K_SB, K_SH})) return K_ILL;
        return k;
    endfunction

    function automatic ctl_t obs_ctl();
        return cur ? b_ctl : a_ctl;
    endfunction

    function automatic logic obs_err();
        return cur ? b_bus_err : a_bus_err;
    endfunction

    // Required strobes for one cycle of an instruction of kind k in phase ph.
    function automatic ctl_t expect_ctl(phase_t ph, kind_t k, logic rdy, logic az);
        ctl_t c = '0;
        case (ph)
            PH_FETCH: begin
                c.mem_req = 1'b1;
                if (rdy) begin
                    c.ir_we = 1'b1;
                    c.pc_we = 1'b1;
                end
            end
            PH_DECODE: begin
                if (k inside {K_J, K_JAL, K_JR, K_JALR}) begin
                    c.pc_we      = 1'b1;
                    c.pc_src     = (k inside {K_J, K_JAL}) ? 2'd2 : 2'd3;
                    c.instr_done = 1'b1;
                end
                if (k == K_JAL) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 2'd2;
                    c.wb_sel    = 2'd2;
                end
                if (k == K_JALR) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 2'd1;
                    c.wb_sel    = 2'd2;
                end
                if (k == K_ILL) c.illegal = 1'b1;
            end
            PH_EXEC: begin
                if (k == K_SUBU) c.alu_op = 4'd1;
                if (k == K_ORI || k == K_LUI) begin
                    c.alu_src = 1'b1;
                    c.ext_op  = (k == K_LUI) ? 2'd1 : 2'd0;
                    c.alu_op  = 4'd2;
                end
                if (is_load(k) || is_store(k)) begin
                    c.alu_src = 1'b1;
                    c.ext_op  = 2'd2;
                end
                if (k == K_BEQ || k == K_BNE) begin
                    c.alu_op     = 4'd1;
                    c.instr_done = 1'b1;
                    if (az == (k == K_BEQ)) begin
                        c.pc_we  = 1'b1;
                        c.pc_src = 2'd1;
                    end
                end
            end
            PH_MEM: begin
                c.mem_req    = 1'b1;
                c.mem_we     = is_store(k);
                c.mem_size   = size_of(k);
                c.instr_done = rdy && is_store(k);
            end
            PH_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
                if (is_load(k)) c.wb_sel = 2'd1;
                else if (k == K_ADDU || k == K_SUBU) c.reg_dst = 2'd1;
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_rst(logic v);
        if (cur) rst_b = v;
        else rst_a = v;
    endtask

    // Checks one BOOT cycle just after reset release.
    task automatic boot_cycle(string tag);
        @(negedge clk);
        check({tag, "_boot"}, obs_ctl(), '0);
        check({tag, "_boot_bus_err"}, obs_err(), 1'b0);
        @(posedge clk);
        #1;
    endtask

    // One clock of an instruction; inputs were driven by the caller at posedge+1.
    task automatic step(phase_t ph, kind_t k, string tag);
        ctl_t e;
        if (aborted) return;
        e = expect_ctl(ph, k, mem_ready, alu_zero);
        if (ph == abort_at) begin
            #2;
            check({tag, "_pre_abort"}, obs_ctl(), e);
            set_rst(1'b0);
            #1;
            check({tag, "_abort"}, obs_ctl(), '0);
            check({tag, "_abort_bus_err"}, obs_err(), 1'b0);
            @(posedge clk);
            #1;
            set_rst(1'b1);
            boot_cycle(tag);
            aborted = 1'b1;
        end else begin
            @(negedge clk);
            check(tag, obs_ctl(), e);
            check({tag, "_bus_err"}, obs_err(), 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    // Walks one instruction from FETCH: nf/nm wait cycles before mem_ready in FETCH/MEM.
    task automatic run_instr(instr_t ins, int nf, int nm, logic az);
        kind_t k = eff_kind(ins.k);
        string n = ins.k.name();
        for (int w = 0; w <= nf; w++) begin
            op        = 6'($urandom);   // IR not yet valid during fetch
            funct     = 6'($urandom);
            alu_zero  = 1'($urandom);
            mem_ready = (w == nf);
            step(PH_FETCH, k, {n, "_fetch"});
        end
        op        = ins.op;
        funct     = (ins.op == 6'd0) ? ins.funct : 6'($urandom);
        mem_ready = 1'($urandom);
        alu_zero  = 1'($urandom);
        step(PH_DECODE, k, {n, "_decode"});
        if (k inside {K_J, K_JAL, K_JR, K_JALR, K_ILL}) return;
        alu_zero  = az;
        mem_ready = 1'($urandom);
        step(PH_EXEC, k, {n, "_exec"});
        if (k inside {K_BEQ, K_BNE}) return;
        alu_zero = 1'($urandom);
        if (is_load(k) || is_store(k)) begin
            for (int w = 0; w <= nm; w++) begin
                mem_ready = (w == nm);
                step(PH_MEM, k, {n, "_mem"});
            end
            if (is_store(k)) return;
        end
        mem_ready = 1'($urandom);
        step(PH_WB, k, {n, "_wb"});
    endtask

    task automatic run_random(int count);
        for (int i = 0; i < count; i++) begin
            int nf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 2));
            int nm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 2));
            run_instr(tbl[$urandom_range(0, tbl.size() - 1)], nf, nm, 1'($urandom));
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        op = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;

        tbl.push_back(mk(6'h00, 6'h21, K_ADDU));
        tbl.push_back(mk(6'h00, 6'h23, K_SUBU));
        tbl.push_back(mk(6'h00, 6'h08, K_JR));
        tbl.push_back(mk(6'h00, 6'h09, K_JALR));
        tbl.push_back(mk(6'h00, 6'h00, K_ILL));   // sll nop
        tbl.push_back(mk(6'h00, 6'h20, K_ILL));   // add (trapping) unsupported
        tbl.push_back(mk(6'h02, 6'h00, K_J));
        tbl.push_back(mk(6'h03, 6'h00, K_JAL));
        tbl.push_back(mk(6'h04, 6'h00, K_BEQ));
        tbl.push_back(mk(6'h05, 6'h00, K_BNE));
        tbl.push_back(mk(6'h0d, 6'h00, K_ORI));
        tbl.push_back(mk(6'h0f, 6'h00, K_LUI));
        tbl.push_back(mk(6'h23, 6'h00, K_LW));
        tbl.push_back(mk(6'h24, 6'h00, K_LBU));
        tbl.push_back(mk(6'h25, 6'h00, K_LHU));
        tbl.push_back(mk(6'h2b, 6'h00, K_SW));
        tbl.push_back(mk(6'h28, 6'h00, K_SB));
        tbl.push_back(mk(6'h29, 6'h00, K_SH));
        tbl.push_back(mk(6'h08, 6'h00, K_ILL));   // addi unsupported
        tbl.push_back(mk(6'h3f, 6'h00, K_ILL));

        // Reset state of both instances.
        #2;
        check("reset_a_ctl", a_ctl, '0);
        check("reset_a_bus_err", a_bus_err, 1'b0);
        check("reset_b_ctl", b_ctl, '0);
        check("reset_b_bus_err", b_bus_err, 1'b0);

        // ---------------- dut_a: sub-word ops legal ----------------
        cur = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        boot_cycle("a");

        run_instr(mk(6'h00, 6'h21, K_ADDU), 0, 0, 1'b0);
        run_instr(mk(6'h23, 6'h00, K_LW), 0, 3, 1'b0);
        run_instr(mk(6'h04, 6'h00, K_BEQ), 0, 0, 1'b1);
        run_instr(mk(6'h05, 6'h00, K_BNE), 0, 0, 1'b1);
        run_instr(mk(6'h05, 6'h00, K_BNE), 1, 0, 1'b0);
        run_instr(mk(6'h03, 6'h00, K_JAL), 0, 0, 1'b0);
        run_instr(mk(6'h0f, 6'h00, K_LUI), 2, 0, 1'b0);
        run_instr(mk(6'h29, 6'h00, K_SH), 0, 1, 1'b0);
        // mem_ready in the last allowed wait cycle completes normally, and the
        // wait counter restarts between the fetch and the data access.
        run_instr(mk(6'h00, 6'h21, K_ADDU), 15, 0, 1'b0);
        run_instr(mk(6'h23, 6'h00, K_LW), 15, 15, 1'b0);
        run_random(300);

        // Timeout: 16 unanswered fetch cycles, then HALT with sticky bus_err.
        for (int w = 0; w < 16; w++) begin
            op = 6'($urandom);
            mem_ready = 1'b0;
            step(PH_FETCH, K_ADDU, "timeout_fetch");
        end
        for (int i = 0; i < 4; i++) begin
            op = 6'($urandom);
            funct = 6'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            check("halt_ctl", a_ctl, '0);
            check("halt_bus_err", a_bus_err, 1'b1);
            @(posedge clk);
            #1;
        end
        rst_a = 1'b0;
        #1;
        check("halt_reset_ctl", a_ctl, '0);
        check("halt_reset_bus_err", a_bus_err, 1'b0);

        // ---------------- dut_b: sub-word ops illegal ----------------
        cur = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        boot_cycle("b");
        run_instr(mk(6'h28, 6'h00, K_SB), 0, 0, 1'b0);
        run_instr(mk(6'h24, 6'h00, K_LBU), 1, 0, 1'b0);
        run_instr(mk(6'h2b, 6'h00, K_SW), 0, 2, 1'b0);
        run_instr(mk(6'h23, 6'h00, K_LW), 0, 0, 1'b0);
        run_random(100);

        // Reset pulled while a load sits in MEM: request drops at once.
        abort_at = PH_MEM;
        aborted = 1'b0;
        run_instr(mk(6'h23, 6'h00, K_LW), 0, 2, 1'b0);
        abort_at = PH_NONE;
        aborted = 1'b0;
        run_instr(mk(6'h00, 6'h23, K_SUBU), 0, 0, 1'b0);

        // ---------------- dut_a again: reset during WB ----------------
        rst_b = 1'b0;
        cur = 1'b0;
        rst_a = 1'b1;
        boot_cycle("a2");
        abort_at = PH_WB;
        aborted = 1'b0;
        run_instr(mk(6'h00, 6'h21, K_ADDU), 0, 0, 1'b0);
        abort_at = PH_NONE;
        aborted = 1'b0;
        run_instr(mk(6'h0d, 6'h00, K_ORI), 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
